adder_arbiter_rr: RTL and testbench

ADDER_ARBITER_RR -- requirements
Module: adder_arbiter_rr

---
 rtl/adder_arbiter_rr.sv | 83 ++++++++
 tb/tb_adder_arbiter_rr.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter_rr.sv
// Two requesters share one registered WIDTH-bit adder through a round-robin grant.
// The result is held on a valid/ready response channel that supports one result per cycle.
//
// state | meaning
// IDLE  | no result held, rsp_valid=0
// RESP  | result held, rsp_valid=1
module adder_arbiter_rr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  input  logic             rsp_ready
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state, state_nxt;
  logic             prio;
  logic             grant0, grant1;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   sum_full;

  assign grant0 = req0_valid & (~req1_valid | ~prio);
  assign grant1 = req1_valid & (~req0_valid |  prio);

  // Readies are gated by rst_n so nothing is offered while reset is held.
  assign can_accept = rst_n & ((state == IDLE) | rsp_ready);
  assign req0_ready = grant0 & can_accept;
  assign req1_ready = grant1 & can_accept;
  assign xfer       = req0_ready | req1_ready;

  assign op_a     = req1_ready ? req1_a : req0_a;
  assign op_b     = req1_ready ? req1_b : req0_b;
  assign sum_full = {1'b0, op_a} + {1'b0, op_b};

  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (xfer) state_nxt = RESP;
      RESP: begin
        if (xfer)           state_nxt = RESP;
        else if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        rsp_sum   <= sum_full[WIDTH-1:0];
        rsp_carry <= sum_full[WIDTH];
        rsp_id    <= req1_ready;
        // Point at the requester that was not served.
        prio      <= req0_ready;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter_rr.sv
// Directed bench for adder_arbiter_rr with hand-computed expected results.
module tb_adder_arbiter_rr;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready;
  logic             rsp_valid, rsp_id, rsp_carry, rsp_ready;
  logic [WIDTH-1:0] rsp_sum;

  int errors = 0;
  int checks = 0;

  adder_arbiter_rr #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic id,
                           input logic [WIDTH-1:0] sum, input logic c);
    check({tag, ".valid"}, 64'(rsp_valid), 64'(v));
    check({tag, ".id"},    64'(rsp_id),    64'(id));
    check({tag, ".sum"},   64'(rsp_sum),   64'(sum));
    check({tag, ".carry"}, 64'(rsp_carry), 64'(c));
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    #3;
    check_rsp("reset", 1'b0, 1'b0, '0, 1'b0);
    check("reset.rdy0", 64'(req0_ready), 64'd0);
    check("reset.rdy1", 64'(req1_ready), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #9 rst_n = 1'b1;
    cyc();

    // single request
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; rsp_ready = 1'b1;
    #1;
    check("single.rdy0", 64'(req0_ready), 64'd1);
    check("single.rdy1", 64'(req1_ready), 64'd0);
    cyc();
    req0_valid = 1'b0;
    check_rsp("single", 1'b1, 1'b0, 32'd12, 1'b0);
    cyc();
    check("single.idle", 64'(rsp_valid), 64'd0);

    // overflow on requester 1
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0000_0002;
    #1;
    check("ovf.rdy1", 64'(req1_ready), 64'd1);
    cyc();
    req1_valid = 1'b0;
    check_rsp("ovf", 1'b1, 1'b1, 32'h0000_0001, 1'b1);
    cyc();
    check("ovf.idle", 64'(rsp_valid), 64'd0);

    // contention: prio is back at 0, so grants go 0,1,0,1
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd1;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont.rdy0", 64'(req0_ready), 64'(i % 2 == 0));
      check("cont.rdy1", 64'(req1_ready), 64'(i % 2 == 1));
      cyc();
      if (i % 2 == 0) check_rsp("cont", 1'b1, 1'b0, 32'd2, 1'b0);
      else            check_rsp("cont", 1'b1, 1'b1, 32'd30, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    check("cont.idle", 64'(rsp_valid), 64'd0);

    // backpressure: rsp_ready is ignored in IDLE, then holds the result
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd200;
    #1;
    check("bp.idle_rdy0", 64'(req0_ready), 64'd1);
    cyc();
    req0_a = 32'd7; req0_b = 32'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp.rdy0", 64'(req0_ready), 64'd0);
      check("bp.rdy1", 64'(req1_ready), 64'd0);
      check_rsp("bp.hold", 1'b1, 1'b0, 32'd300, 1'b0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp.release_rdy0", 64'(req0_ready), 64'd1);
    cyc();
    check_rsp("bp.next", 1'b1, 1'b0, 32'd15, 1'b0);
    req0_valid = 1'b0;
    cyc();
    check("bp.idle", 64'(rsp_valid), 64'd0);

    // reset while a result is held; prio is 1 before reset
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4;
    cyc();
    req0_valid = 1'b0; rsp_ready = 1'b0;
    check_rsp("rst.held", 1'b1, 1'b0, 32'd7, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_rsp("rst.async", 1'b0, 1'b0, '0, 1'b0);
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3;
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4;
    #1;
    check("rst.rdy0", 64'(req0_ready), 64'd0);
    check("rst.rdy1", 64'(req1_ready), 64'd0);
    #1 rst_n = 1'b1;
    #1;
    check("rst.post_rdy0", 64'(req0_ready), 64'd1);
    cyc();
    check_rsp("rst.first", 1'b1, 1'b0, 32'd5, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    cyc();
    check("rst.idle", 64'(rsp_valid), 64'd0);

    // idle with rsp_ready toggling; prio must stay 1
    for (int i = 0; i < 4; i++) begin
      rsp_ready = ~rsp_ready;
      cyc();
      check("idle.valid", 64'(rsp_valid), 64'd0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("idle.rdy0", 64'(req0_ready), 64'd0);
    check("idle.rdy1", 64'(req1_ready), 64'd1);
    cyc();
    check_rsp("idle.grant1", 1'b1, 1'b1, 32'd8, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    cyc();
    check("end.idle", 64'(rsp_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
